// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared constants, state encoding and helpers for the UART transmitter
package uart_pkg;

    localparam logic [1:0] PAR_NONE = 2'd0;
    localparam logic [1:0] PAR_EVEN = 2'd1;
    localparam logic [1:0] PAR_ODD  = 2'd2;

    localparam logic [1:0] LEN_5 = 2'd0;
    localparam logic [1:0] LEN_6 = 2'd1;
    localparam logic [1:0] LEN_7 = 2'd2;
    localparam logic [1:0] LEN_8 = 2'd3;

    localparam int DIV_MIN = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } tx_state_e;

    function automatic logic [3:0] data_bits(input logic [1:0] len);
        return {2'b00, len} + 4'd5;
    endfunction

    function automatic logic [7:0] len_mask(input logic [1:0] len);
        unique case (len)
            LEN_5: return 8'h1F;
            LEN_6: return 8'h3F;
            LEN_7: return 8'h7F;
            LEN_8: return 8'hFF;
        endcase
    endfunction

    function automatic logic parity_enabled(input logic [1:0] mode);
        return (mode == PAR_EVEN) || (mode == PAR_ODD);
    endfunction

    function automatic logic frame_parity(input logic [7:0] data, input logic [1:0] len,
                                          input logic [1:0] mode);
        return (^(data & len_mask(len))) ^ (mode == PAR_ODD);
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - synchronous input queue feeding the UART transmitter
module uart_tx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE  = (AW+1)'(1);
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             do_push, do_pop;

    assign level   = wr_ptr_q - rd_ptr_q;
    assign full    = (level == FULL_LVL);
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/uart_tx_param.sv
// rtl/uart_tx_param.sv - queued UART transmitter with runtime baud, length, parity and stop config
module uart_tx_param
    import uart_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int DIV_W      = 16,
    parameter int DATA_W     = 8
) (
    input  logic                          Clk,
    input  logic                          Reset,
    input  logic [DATA_W-1:0]             Data,
    input  logic                          Data_valid,
    output logic                          Data_ready,
    input  logic [DIV_W-1:0]              Baud_div,
    input  logic [1:0]                    Data_len,
    input  logic [1:0]                    Parity_mode,
    input  logic                          Stop_bits,
    output logic                          uart_tx,
    output logic                          Tx_done,
    output logic                          Busy,
    output logic [$clog2(FIFO_DEPTH):0]   Fifo_level
);

    localparam logic [DIV_W-1:0] DIV_ONE = DIV_W'(1);
    localparam logic [DIV_W-1:0] DIV_LO  = DIV_W'(DIV_MIN);

    tx_state_e         state_q, state_d;
    logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
    logic [DIV_W-1:0]  div_lat_q, div_lat_d;
    logic [3:0]        bit_cnt_q, bit_cnt_d;
    logic [3:0]        nbits_q, nbits_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              parity_q, parity_d;
    logic [1:0]        par_mode_q, par_mode_d;
    logic              two_stop_q, two_stop_d;
    logic              tx_q, tx_d;
    logic              done_q, done_d;

    logic              fifo_full, fifo_empty, fifo_pop, fifo_push;
    logic [DATA_W-1:0] fifo_head;
    logic              bit_end, start_frame;

    assign Data_ready = !fifo_full && !Reset;
    assign fifo_push  = Data_valid && Data_ready;

    uart_tx_fifo #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk    (Clk),
        .resetn (!Reset),
        .push   (fifo_push),
        .wdata  (Data),
        .pop    (fifo_pop),
        .rdata  (fifo_head),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .level  (Fifo_level)
    );

    assign bit_end = (div_cnt_q == div_lat_q - DIV_ONE);

    always_comb begin
        state_d     = state_q;
        div_lat_d   = div_lat_q;
        bit_cnt_d   = bit_cnt_q;
        nbits_d     = nbits_q;
        shift_d     = shift_q;
        parity_d    = parity_q;
        par_mode_d  = par_mode_q;
        two_stop_d  = two_stop_q;
        tx_d        = tx_q;
        done_d      = 1'b0;
        fifo_pop    = 1'b0;
        start_frame = 1'b0;

        if (state_q == ST_IDLE || bit_end) div_cnt_d = '0;
        else                               div_cnt_d = div_cnt_q + DIV_ONE;

        unique case (state_q)
            ST_IDLE: start_frame = !fifo_empty;
            ST_START: if (bit_end) begin
                state_d   = ST_DATA;
                tx_d      = shift_q[0];
                shift_d   = shift_q >> 1;
                bit_cnt_d = 4'd1;
            end
            ST_DATA: if (bit_end) begin
                if (bit_cnt_q != nbits_q) begin
                    tx_d      = shift_q[0];
                    shift_d   = shift_q >> 1;
                    bit_cnt_d = bit_cnt_q + 4'd1;
                end else if (parity_enabled(par_mode_q)) begin
                    state_d = ST_PARITY;
                    tx_d    = parity_q;
                end else begin
                    state_d   = ST_STOP;
                    tx_d      = 1'b1;
                    bit_cnt_d = 4'd1;
                end
            end
            ST_PARITY: if (bit_end) begin
                state_d   = ST_STOP;
                tx_d      = 1'b1;
                bit_cnt_d = 4'd1;
            end
            ST_STOP: if (bit_end) begin
                if (two_stop_q && bit_cnt_q == 4'd1) begin
                    bit_cnt_d = 4'd2;
                end else begin
                    done_d      = 1'b1;
                    state_d     = ST_IDLE;
                    tx_d        = 1'b1;
                    start_frame = !fifo_empty;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Config is captured here so mid-frame input changes only affect the next frame
        if (start_frame) begin
            fifo_pop   = 1'b1;
            state_d    = ST_START;
            tx_d       = 1'b0;
            shift_d    = fifo_head;
            div_cnt_d  = '0;
            bit_cnt_d  = '0;
            div_lat_d  = (Baud_div < DIV_LO) ? DIV_LO : Baud_div;
            nbits_d    = data_bits(Data_len);
            par_mode_d = Parity_mode;
            two_stop_d = Stop_bits;
            parity_d   = frame_parity(fifo_head[7:0], Data_len, Parity_mode);
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q    <= ST_IDLE;
            div_cnt_q  <= '0;
            div_lat_q  <= '0;
            bit_cnt_q  <= '0;
            nbits_q    <= '0;
            shift_q    <= '0;
            parity_q   <= 1'b0;
            par_mode_q <= PAR_NONE;
            two_stop_q <= 1'b0;
            tx_q       <= 1'b1;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_cnt_q  <= div_cnt_d;
            div_lat_q  <= div_lat_d;
            bit_cnt_q  <= bit_cnt_d;
            nbits_q    <= nbits_d;
            shift_q    <= shift_d;
            parity_q   <= parity_d;
            par_mode_q <= par_mode_d;
            two_stop_q <= two_stop_d;
            tx_q       <= tx_d;
            done_q     <= done_d;
        end
    end

    assign uart_tx = tx_q;
    assign Tx_done = done_q;
    assign Busy    = (state_q != ST_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_uart_tx_param.sv
// tb/tb_uart_tx_param.sv - self-checking bench for uart_tx_param
module tb_uart_tx_param;

    typedef struct {
        logic [11:0] pattern;
        int          nbits;
        int          div;
        int          len;
    } exp_t;

    typedef struct {
        logic [7:0]  data;
        logic [15:0] baud;
        logic [1:0]  dlen;
        logic [1:0]  pmode;
        logic        sbits;
        exp_t        exp;
    } vec_t;

    logic        clk;
    logic        Reset;
    logic [7:0]  Data;
    logic        Data_valid;
    logic        Data_ready;
    logic [15:0] Baud_div;
    logic [1:0]  Data_len;
    logic [1:0]  Parity_mode;
    logic        Stop_bits;
    logic        uart_tx;
    logic        Tx_done;
    logic        Busy;
    logic [2:0]  Fifo_level;

    int   n_checks = 0;
    int   n_pass = 0;
    int   frames_done = 0;
    int   back_to_back = 0;
    int   done_cnt = 0;
    bit   mon_en = 0;
    exp_t sb_q[$];
    vec_t vecs[7];

    uart_tx_param #(.FIFO_DEPTH(4), .DIV_W(16), .DATA_W(8)) dut (
        .Clk         (clk),
        .Reset       (Reset),
        .Data        (Data),
        .Data_valid  (Data_valid),
        .Data_ready  (Data_ready),
        .Baud_div    (Baud_div),
        .Data_len    (Data_len),
        .Parity_mode (Parity_mode),
        .Stop_bits   (Stop_bits),
        .uart_tx     (uart_tx),
        .Tx_done     (Tx_done),
        .Busy        (Busy),
        .Fifo_level  (Fifo_level)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", n_pass, n_checks);
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic exp_t make_exp(input logic [7:0] d, input int nd, input int pm,
                                      input int ns, input int div);
        exp_t e;
        int   idx;
        logic p;
        e.pattern = '0;
        idx = 1;
        p = (pm == 2);
        for (int i = 0; i < nd; i++) begin
            e.pattern[idx] = d[i];
            p ^= d[i];
            idx++;
        end
        if (pm == 1 || pm == 2) begin
            e.pattern[idx] = p;
            idx++;
        end
        for (int i = 0; i < ns; i++) begin
            e.pattern[idx] = 1'b1;
            idx++;
        end
        e.nbits = idx;
        e.div   = div;
        e.len   = idx * div;
        return e;
    endfunction

    function automatic vec_t mk_vec(input logic [7:0] d, input logic [15:0] baud, input logic [1:0] dlen,
                                    input logic [1:0] pm, input logic sb, input logic [11:0] pat,
                                    input int nbits, input int div, input int len);
        vec_t v;
        v.data = d; v.baud = baud; v.dlen = dlen; v.pmode = pm; v.sbits = sb;
        v.exp.pattern = pat; v.exp.nbits = nbits; v.exp.div = div; v.exp.len = len;
        return v;
    endfunction

    task automatic push_byte(input logic [7:0] d, input exp_t e, input bit track);
        int n;
        n = 0;
        Data = d;
        Data_valid = 1'b1;
        while (Data_ready !== 1'b1 && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("push_accepted", Data_ready, 1);
        if (track) sb_q.push_back(e);
        @(negedge clk);
        Data_valid = 1'b0;
    endtask

    task automatic wait_frames(input int target, input int budget);
        int n;
        n = 0;
        while (frames_done < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("frames_done", frames_done, target);
        repeat (2) @(negedge clk);
    endtask

    task automatic mon_frames();
        exp_t e;
        int   k;
        bit   ok;
        bit   more;
        more = 1;
        while (more) begin
            chk("sb_nonempty", sb_q.size() > 0, 1);
            if (sb_q.size() == 0) begin
                k = 0;
                while (Tx_done !== 1'b1 && k < 500) begin
                    @(negedge clk);
                    k++;
                end
                more = 0;
            end else begin
                e = sb_q.pop_front();
                ok = 1;
                k = 0;
                while (!(k > 0 && Tx_done === 1'b1) && k < 2 * e.len + 20) begin
                    if (k < e.nbits * e.div && uart_tx !== e.pattern[k / e.div]) ok = 0;
                    @(negedge clk);
                    k++;
                end
                chk("frame_bits", ok, 1);
                chk("frame_len", k, e.len);
                frames_done++;
                if (uart_tx === 1'b0) begin
                    back_to_back++;
                end else begin
                    chk("busy_after_frame", Busy, Fifo_level != 0);
                    more = 0;
                end
            end
        end
    endtask

    initial begin : monitor
        forever begin
            @(negedge clk);
            if (mon_en && uart_tx === 1'b0) mon_frames();
        end
    end

    initial begin : done_counter
        forever begin
            @(negedge clk);
            if (Tx_done === 1'b1) done_cnt++;
        end
    end

    initial begin : main
        logic [7:0] bb [5];
        exp_t       dummy;
        int         base, b2b_base, dn_base;
        bit         line_ok;

        vecs[0] = mk_vec(8'hA5, 16'd10, 2'd3, 2'd0, 1'b0, {1'b1, 8'hA5, 1'b0},              10, 10, 100);
        vecs[1] = mk_vec(8'h07, 16'd4,  2'd2, 2'd1, 1'b1, {2'b11, 1'b1, 7'h07, 1'b0},       11, 4,  44);
        vecs[2] = mk_vec(8'h00, 16'd3,  2'd0, 2'd2, 1'b0, {1'b1, 1'b1, 5'h00, 1'b0},         8, 3,  24);
        vecs[3] = mk_vec(8'h5A, 16'd5,  2'd1, 2'd2, 1'b0, {1'b1, 1'b0, 6'h1A, 1'b0},         9, 5,  45);
        vecs[4] = mk_vec(8'hFF, 16'd0,  2'd3, 2'd1, 1'b0, {1'b1, 1'b0, 8'hFF, 1'b0},        11, 2,  22);
        vecs[5] = mk_vec(8'h3C, 16'd1,  2'd3, 2'd3, 1'b0, {1'b1, 8'h3C, 1'b0},              10, 2,  20);
        vecs[6] = mk_vec(8'h96, 16'd3,  2'd2, 2'd2, 1'b1, {2'b11, 1'b0, 7'h16, 1'b0},       11, 3,  33);
        bb[0] = 8'h81; bb[1] = 8'h3C; bb[2] = 8'hE7; bb[3] = 8'h00; bb[4] = 8'hFF;
        dummy = make_exp(8'h00, 8, 0, 1, 4);

        Reset = 1'b1; Data = '0; Data_valid = 1'b0;
        Baud_div = 16'd10; Data_len = 2'd3; Parity_mode = 2'd0; Stop_bits = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_tx", uart_tx, 1);
        chk("reset_done", Tx_done, 0);
        chk("reset_busy", Busy, 0);
        chk("reset_level", Fifo_level, 0);
        chk("reset_ready", Data_ready, 0);
        Reset = 1'b0;
        #1;
        chk("ready_after_reset", Data_ready, 1);
        @(negedge clk);
        mon_en = 1;

        for (int i = 0; i < 7; i++) begin
            Baud_div = vecs[i].baud; Data_len = vecs[i].dlen;
            Parity_mode = vecs[i].pmode; Stop_bits = vecs[i].sbits;
            base = frames_done;
            push_byte(vecs[i].data, vecs[i].exp, 1'b1);
            chk("idle_before_start", uart_tx, 1);
            chk("level_after_push", Fifo_level, 1);
            @(negedge clk);
            chk("start_latency", uart_tx, 0);
            chk("level_after_pop", Fifo_level, 0);
            wait_frames(base + 1, 2000);
            chk("vec_idle_busy", Busy, 0);
        end

        Baud_div = 16'd4; Data_len = 2'd3; Parity_mode = 2'd0; Stop_bits = 1'b0;
        base = frames_done; b2b_base = back_to_back; dn_base = done_cnt;
        for (int i = 0; i < 5; i++) push_byte(bb[i], make_exp(bb[i], 8, 0, 1, 4), 1'b1);
        chk("full_level", Fifo_level, 4);
        chk("full_ready", Data_ready, 0);
        Data = 8'hEE; Data_valid = 1'b1;
        repeat (3) @(negedge clk);
        chk("full_level_hold", Fifo_level, 4);
        Data_valid = 1'b0;
        wait_frames(base + 5, 1500);
        chk("b2b_no_gap", back_to_back - b2b_base, 4);
        chk("b2b_done_pulses", done_cnt - dn_base, 5);
        chk("b2b_final_level", Fifo_level, 0);
        chk("b2b_final_busy", Busy, 0);

        Baud_div = 16'd10;
        base = frames_done; b2b_base = back_to_back;
        push_byte(8'h81, make_exp(8'h81, 8, 0, 1, 10), 1'b1);
        repeat (30) @(negedge clk);
        Baud_div = 16'd20;
        push_byte(8'h42, make_exp(8'h42, 8, 0, 1, 20), 1'b1);
        wait_frames(base + 2, 2000);
        chk("cfg_b2b", back_to_back - b2b_base, 1);

        mon_en = 0;
        Baud_div = 16'd4;
        dn_base = done_cnt;
        push_byte(8'hF7, dummy, 1'b0);
        push_byte(8'h11, dummy, 1'b0);
        push_byte(8'h22, dummy, 1'b0);
        chk("queued_level", Fifo_level, 2);
        repeat (16) @(negedge clk);
        chk("pre_reset_line", uart_tx, 0);
        Reset = 1'b1;
        #1;
        chk("ready_in_reset", Data_ready, 0);
        @(negedge clk);
        chk("reset_mid_tx", uart_tx, 1);
        chk("reset_mid_level", Fifo_level, 0);
        chk("reset_mid_busy", Busy, 0);
        chk("reset_mid_done", Tx_done, 0);
        Reset = 1'b0;
        line_ok = 1;
        repeat (60) begin
            @(negedge clk);
            if (uart_tx !== 1'b1) line_ok = 0;
        end
        chk("line_idle_after_reset", line_ok, 1);
        chk("no_done_after_reset", done_cnt - dn_base, 0);
        chk("ready_after_mid_reset", Data_ready, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
